// File: rtl/sprite_line_scheduler_pkg.sv
// Shared types and defaults for the sprite line scheduler and the fluid sprite datapath.
// Scheduler FSM encoding, default geometry and a small saturating-increment helper.
package sprite_line_scheduler_pkg;

  localparam int unsigned DEF_SPR_H = 8;
  localparam int unsigned DEF_CW    = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } sched_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_row_match.sv
// Combinational line-coverage test for one sprite entry; shared with the pixel datapath.
// Distance is a modular CW-bit subtraction, so entries below the line wrap to a large d and miss.
module sprite_row_match
  import sprite_line_scheduler_pkg::*;
#(
  parameter int unsigned CW    = DEF_CW,
  parameter int unsigned SPR_H = DEF_SPR_H,
  localparam int unsigned RW   = $clog2(SPR_H)
) (
  input  logic [CW-1:0] i_next_y,
  input  logic [CW-1:0] i_attr_y,
  input  logic          i_attr_en,
  output logic          o_hit,
  output logic [RW-1:0] o_row
);

  logic [CW-1:0] w_d;

  assign w_d   = i_next_y - i_attr_y;
  assign o_hit = i_attr_en && (w_d < CW'(SPR_H));
  assign o_row = w_d[RW-1:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans attribute entries in hblank and commits up to SLOTS hits.
// Optional overflow statistics are built when SPRITE_SCHED_STATS_EN is defined.
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int unsigned MAX_SPRITES = 8,
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned SPR_H       = DEF_SPR_H,
  parameter int unsigned CW          = DEF_CW,
  localparam int unsigned IW         = $clog2(MAX_SPRITES),
  localparam int unsigned RW         = $clog2(SPR_H)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_frame_start,
  input  logic                i_line_start,
  input  logic [CW-1:0]       i_next_y,
  output logic                o_attr_req,
  output logic [IW-1:0]       o_attr_idx,
  input  logic                i_attr_ack,
  input  logic                i_attr_en,
  input  logic [CW-1:0]       i_attr_x,
  input  logic [CW-1:0]       i_attr_y,
  output logic [SLOTS-1:0]    o_slot_valid,
  output logic [SLOTS*CW-1:0] o_slot_x,
  output logic [SLOTS*RW-1:0] o_slot_row,
  output logic [SLOTS*IW-1:0] o_slot_id,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_line_ovf,
  output logic                o_ovf_irq,
  input  logic                i_irq_clear,
  output logic [7:0]          o_ovf_count
);

  sched_state_e r_state;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_y;
  logic          r_req;
  logic          r_busy;
  logic          r_done;
  logic          r_line_ovf;
  logic          r_irq;

  // Shadow bank is filled during the scan; committed bank is what the datapath reads.
  logic [SLOTS-1:0] r_sh_valid;
  logic [CW-1:0]    r_sh_x   [SLOTS];
  logic [RW-1:0]    r_sh_row [SLOTS];
  logic [IW-1:0]    r_sh_id  [SLOTS];
  logic             r_sh_ovf;

  logic [SLOTS-1:0] r_sl_valid;
  logic [CW-1:0]    r_sl_x   [SLOTS];
  logic [RW-1:0]    r_sl_row [SLOTS];
  logic [IW-1:0]    r_sl_id  [SLOTS];

  logic             w_hit;
  logic [RW-1:0]    w_row;
  logic             w_eval;
  logic             w_last;
  logic             w_commit;
  logic             w_commit_ovf;
  logic [SLOTS-1:0] w_pick;
  logic             w_any_free;

  logic [SLOTS-1:0] w_nx_valid;
  logic [CW-1:0]    w_nx_x   [SLOTS];
  logic [RW-1:0]    w_nx_row [SLOTS];
  logic [IW-1:0]    w_nx_id  [SLOTS];
  logic             w_nx_ovf;

  sprite_row_match #(
    .CW    (CW),
    .SPR_H (SPR_H)
  ) u_row_match (
    .i_next_y  (r_y),
    .i_attr_y  (i_attr_y),
    .i_attr_en (i_attr_en),
    .o_hit     (w_hit),
    .o_row     (w_row)
  );

  assign w_eval       = (r_state == S_SCAN) && i_attr_ack;
  assign w_last       = (r_idx == IW'(MAX_SPRITES - 1));
  // Aborts (frame or line start) pre-empt a commit landing on the same edge.
  assign w_commit     = w_eval && w_last && !i_frame_start && !i_line_start;
  assign w_commit_ovf = w_commit && w_nx_ovf;

  always_comb begin
    w_pick     = '0;
    w_any_free = 1'b0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (!r_sh_valid[k]) begin
        w_pick     = '0;
        w_pick[k]  = 1'b1;
        w_any_free = 1'b1;
      end
    end
  end

  // Shadow state including the entry being acked this cycle, so the last entry commits directly.
  always_comb begin
    w_nx_valid = r_sh_valid;
    w_nx_ovf   = r_sh_ovf;
    for (int k = 0; k < SLOTS; k++) begin
      w_nx_x[k]   = r_sh_x[k];
      w_nx_row[k] = r_sh_row[k];
      w_nx_id[k]  = r_sh_id[k];
    end
    if (w_eval && w_hit) begin
      if (w_any_free) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (w_pick[k]) begin
            w_nx_valid[k] = 1'b1;
            w_nx_x[k]     = i_attr_x;
            w_nx_row[k]   = w_row;
            w_nx_id[k]    = r_idx;
          end
        end
      end else begin
        w_nx_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_y        <= '0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_line_ovf <= 1'b0;
      r_sh_valid <= '0;
      r_sh_ovf   <= 1'b0;
      r_sl_valid <= '0;
      for (int k = 0; k < SLOTS; k++) begin
        r_sh_x[k]   <= '0;
        r_sh_row[k] <= '0;
        r_sh_id[k]  <= '0;
        r_sl_x[k]   <= '0;
        r_sl_row[k] <= '0;
        r_sl_id[k]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (i_frame_start) begin
        r_sl_valid <= '0;
        r_line_ovf <= 1'b0;
        r_state    <= S_IDLE;
        r_req      <= 1'b0;
        r_busy     <= 1'b0;
      end
      if (i_line_start) begin
        r_state    <= S_SCAN;
        r_idx      <= '0;
        r_y        <= i_next_y;
        r_req      <= 1'b1;
        r_busy     <= 1'b1;
        r_sh_valid <= '0;
        r_sh_ovf   <= 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
          r_sh_x[k]   <= '0;
          r_sh_row[k] <= '0;
          r_sh_id[k]  <= '0;
        end
      end else if (!i_frame_start) begin
        unique case (r_state)
          S_SCAN: begin
            if (i_attr_ack) begin
              r_sh_valid <= w_nx_valid;
              r_sh_ovf   <= w_nx_ovf;
              for (int k = 0; k < SLOTS; k++) begin
                r_sh_x[k]   <= w_nx_x[k];
                r_sh_row[k] <= w_nx_row[k];
                r_sh_id[k]  <= w_nx_id[k];
              end
              if (w_last) begin
                r_state    <= S_COMMIT;
                r_req      <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_line_ovf <= w_nx_ovf;
                r_sl_valid <= w_nx_valid;
                for (int k = 0; k < SLOTS; k++) begin
                  r_sl_x[k]   <= w_nx_x[k];
                  r_sl_row[k] <= w_nx_row[k];
                  r_sl_id[k]  <= w_nx_id[k];
                end
              end else begin
                r_idx <= r_idx + IW'(1);
              end
            end
          end
          S_COMMIT: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  // The commit edge loads ovf_irq together with done; a clear on that same edge loses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else if (w_commit_ovf) begin
      r_irq <= 1'b1;
    end else if (i_irq_clear) begin
      r_irq <= 1'b0;
    end
  end

`ifdef SPRITE_SCHED_STATS_EN
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_ovf_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf_cnt   <= '0;
      r_ovf_count <= '0;
    end else if (i_frame_start) begin
      r_ovf_count <= r_ovf_cnt;
      r_ovf_cnt   <= '0;
    end else if (w_commit_ovf) begin
      r_ovf_cnt <= sat_inc8(r_ovf_cnt);
    end
  end

  assign o_ovf_count = r_ovf_count;
`else
  assign o_ovf_count = 8'd0;
`endif

  for (genvar k = 0; k < SLOTS; k++) begin : g_pack
    assign o_slot_x[k*CW +: CW]   = r_sl_x[k];
    assign o_slot_row[k*RW +: RW] = r_sl_row[k];
    assign o_slot_id[k*IW +: IW]  = r_sl_id[k];
  end

  assign o_attr_req   = r_req;
  assign o_attr_idx   = r_idx;
  assign o_slot_valid = r_sl_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_line_ovf   = r_line_ovf;
  assign o_ovf_irq    = r_irq;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: vector table plus scoreboard of committed lines.
// Expected ovf_count depends on SPRITE_SCHED_STATS_EN.
module tb_sprite_line_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start, line_start, irq_clear;
  logic [9:0]   next_y;
  logic         attr_req, attr_ack, attr_en;
  logic [2:0]   attr_idx;
  logic [9:0]   attr_x, attr_y;
  logic [3:0]   slot_valid;
  logic [39:0]  slot_x;
  logic [11:0]  slot_row, slot_id;
  logic         busy, done, line_ovf, ovf_irq;
  logic [7:0]   ovf_count;

  always #5 clk = ~clk;

  sprite_line_scheduler u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_start (frame_start),
    .i_line_start  (line_start),
    .i_next_y      (next_y),
    .o_attr_req    (attr_req),
    .o_attr_idx    (attr_idx),
    .i_attr_ack    (attr_ack),
    .i_attr_en     (attr_en),
    .i_attr_x      (attr_x),
    .i_attr_y      (attr_y),
    .o_slot_valid  (slot_valid),
    .o_slot_x      (slot_x),
    .o_slot_row    (slot_row),
    .o_slot_id     (slot_id),
    .o_busy        (busy),
    .o_done        (done),
    .o_line_ovf    (line_ovf),
    .o_ovf_irq     (ovf_irq),
    .i_irq_clear   (irq_clear),
    .o_ovf_count   (ovf_count)
  );

  typedef struct packed {
    logic [9:0]  ny;
    logic [7:0]  en;
    logic [79:0] ys;
    logic [3:0]  wt;
    logic [3:0]  v;
    logic [11:0] ids;
    logic [11:0] rows;
    logic        ovf;
    logic [7:0]  lat;
  } vec_t;

  typedef struct {
    logic [3:0]  v;
    logic [11:0] ids;
    logic [11:0] rows;
    logic        ovf;
    int          lat;
    int          start;
  } exp_t;

  exp_t q[$];
  vec_t vecs[9];
  int total = 0, bad = 0, cyc = 0, n_done = 0, n_exp = 0;
  int tb_wait = 0, wcnt = 0;
  logic [9:0] tb_y[8];
  logic       tb_en[8];
  logic       fs_q = 1'b0;
  logic       prev_wait = 1'b0;
  logic [2:0] prev_idx = '0;
  logic [67:0] prev_slots = '0;

  function automatic logic [9:0] xof(input logic [2:0] id);
    return 10'(int'(id) * 10 + 3);
  endfunction

  // Attribute RAM model: ack after tb_wait cycles of a held request.
  assign attr_ack = attr_req && (wcnt == tb_wait);
  assign attr_en  = tb_en[attr_idx];
  assign attr_y   = tb_y[attr_idx];
  assign attr_x   = xof(attr_idx);

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    fs_q <= frame_start;
    if (attr_req && !attr_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic [11:0] m_ids, m_rows;
      logic [39:0] m_x, e_x;
      exp_t e;
      if (prev_wait) chk("req_hold", {attr_req, attr_idx}, {1'b1, prev_idx});
      prev_wait = attr_req && !attr_ack;
      prev_idx  = attr_idx;
      if (!done && !fs_q) chk("slot_stable", {slot_valid, slot_x, slot_row, slot_id}, prev_slots);
      prev_slots = {slot_valid, slot_x, slot_row, slot_id};
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_expected: got done with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          m_ids = '0; m_rows = '0; m_x = '0; e_x = '0;
          for (int k = 0; k < 4; k++) begin
            if (e.v[k]) begin
              m_ids[k*3 +: 3]   = slot_id[k*3 +: 3];
              m_rows[k*3 +: 3]  = slot_row[k*3 +: 3];
              m_x[k*10 +: 10]   = slot_x[k*10 +: 10];
              e_x[k*10 +: 10]   = xof(e.ids[k*3 +: 3]);
            end
          end
          chk("slot_valid", slot_valid, e.v);
          chk("slot_id", m_ids, e.ids);
          chk("slot_row", m_rows, e.rows);
          chk("slot_x", m_x, e_x);
          chk("line_ovf", line_ovf, e.ovf);
          chk("done_latency", cyc - e.start, e.lat);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(logic [9:0] ny, logic [7:0] en, logic [79:0] ys, logic [3:0] wt,
                               logic [3:0] v, logic [11:0] ids, logic [11:0] rows, logic ovf,
                               logic [7:0] lat);
    vec_t r;
    r.ny = ny; r.en = en; r.ys = ys; r.wt = wt; r.v = v;
    r.ids = ids; r.rows = rows; r.ovf = ovf; r.lat = lat;
    return r;
  endfunction

  function automatic exp_t mke(logic [3:0] v, logic [11:0] ids, logic [11:0] rows, logic ovf,
                               int lat);
    exp_t e;
    e.v = v; e.ids = ids; e.rows = rows; e.ovf = ovf; e.lat = lat; e.start = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      tb_en[i] = v.en[i];
      tb_y[i]  = v.ys[i*10 +: 10];
    end
    tb_wait = int'(v.wt);
  endtask

  task automatic start_line(input logic [9:0] ny, input exp_t e);
    next_y     = ny;
    line_start = 1'b1;
    if (busy) begin
      void'(q.pop_back());
      n_exp--;
    end
    e.start = cyc;
    q.push_back(e);
    n_exp++;
    tick();
    line_start = 1'b0;
    next_y     = 10'h3FF;  // must be ignored once latched
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending lines want 0", q.size());
      n_exp -= q.size();
      q.delete();
    end
  endtask

  task automatic wait_idx(input logic [2:0] k);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (attr_req && attr_idx == k) found = 1;
      else tick();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wait_idx: got no request for idx want %0d", k);
    end
  endtask

  task automatic run_vec(input vec_t v);
    load(v);
    start_line(v.ny, mke(v.v, v.ids, v.rows, v.ovf, int'(v.lat)));
    wait_done();
  endtask

  initial begin
    rst = 1'b1; frame_start = 0; line_start = 0; irq_clear = 0; next_y = '0;
    for (int i = 0; i < 8; i++) begin tb_en[i] = 0; tb_y[i] = '0; end

    vecs[0] = mkv(10'd103, 8'hFF, {8{10'd100}}, 4'd0, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0},
                  {4{3'd3}}, 1'b1, 8'd9);
    vecs[1] = mkv(10'd107, 8'hFB, {10'd104, 10'd1020, 10'd108, 10'd107, 10'd1023, 10'd100,
                  10'd99, 10'd100}, 4'd0, 4'b0111, {3'd0, 3'd7, 3'd4, 3'd0},
                  {3'd0, 3'd3, 3'd0, 3'd7}, 1'b0, 8'd9);
    vecs[2] = mkv(10'd108, 8'hFF, {8{10'd100}}, 4'd0, 4'h0, 12'd0, 12'd0, 1'b0, 8'd9);
    // y=1023 covers lines 1023,0..6, so next_y=5 hits at row 6; y=10 wraps and misses.
    vecs[3] = mkv(10'd5, 8'h0F, {10'd5, 10'd5, 10'd5, 10'd5, 10'd5, 10'd1000, 10'd10,
                  10'd1023}, 4'd0, 4'b0011, {3'd0, 3'd0, 3'd3, 3'd0},
                  {3'd0, 3'd0, 3'd0, 3'd6}, 1'b0, 8'd9);
    vecs[4] = mkv(10'd103, 8'hFF, {8{10'd100}}, 4'd2, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0},
                  {4{3'd3}}, 1'b1, 8'd25);
    vecs[5] = mkv(10'd100, 8'h55, {8{10'd100}}, 4'd1, 4'hF, {3'd6, 3'd4, 3'd2, 3'd0},
                  12'd0, 1'b0, 8'd17);
    vecs[6] = mkv(10'd0, 8'hF0, {8{10'd1021}}, 4'd0, 4'hF, {3'd7, 3'd6, 3'd5, 3'd4},
                  {4{3'd3}}, 1'b0, 8'd9);
    vecs[7] = mkv(10'd100, 8'h0F, {8{10'd97}}, 4'd0, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0},
                  {4{3'd3}}, 1'b0, 8'd9);
    vecs[8] = mkv(10'd100, 8'h1F, {8{10'd97}}, 4'd0, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0},
                  {4{3'd3}}, 1'b1, 8'd9);

    repeat (2) tick();
    chk("reset_ctrl", {attr_req, attr_idx, busy, done, line_ovf, ovf_irq, ovf_count}, '0);
    chk("reset_slots", {slot_valid, slot_x, slot_row, slot_id}, '0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    chk("irq_sticky", ovf_irq, 1'b1);
    irq_clear = 1'b1; tick(); irq_clear = 1'b0;
    chk("irq_clear", ovf_irq, 1'b0);
    run_vec(vecs[7]);
    chk("irq_no_set", ovf_irq, 1'b0);

    // frame_start and line_start together mid-scan
    run_vec(vecs[0]);
    load(vecs[0]);
    start_line(10'd103, mke(4'hF, 12'h0D1, {4{3'd3}}, 1'b1, 9));
    wait_idx(3'd3);
    frame_start = 1'b1;
    start_line(10'd103, mke(4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, {4{3'd3}}, 1'b1, 9));
    frame_start = 1'b0;
    chk("fs_valid_clear", slot_valid, 4'h0);
    chk("fs_ovf_clear", line_ovf, 1'b0);
    chk("fs_rescan_busy", busy, 1'b1);
    wait_done();

    // restart at idx 4: only the second line commits
    for (int i = 0; i < 8; i++) begin tb_en[i] = 1; tb_y[i] = '0; end
    tb_y[6] = 10'd198;
    tb_wait = 0;
    start_line(10'd103, mke(4'h0, 12'd0, 12'd0, 1'b0, 9));
    wait_idx(3'd4);
    start_line(10'd200, mke(4'b0001, {9'd0, 3'd6}, {9'd0, 3'd2}, 1'b0, 9));
    wait_done();

    // frame_start alone aborts the scan with no done
    load(vecs[1]);
    start_line(vecs[1].ny, mke(vecs[1].v, vecs[1].ids, vecs[1].rows, 1'b0, 9));
    wait_idx(3'd2);
    frame_start = 1'b1;
    if (busy) begin void'(q.pop_back()); n_exp--; end
    tick();
    frame_start = 1'b0;
    chk("abort_idle", {busy, attr_req, slot_valid}, 6'd0);
    repeat (12) tick();

    // set and clear of ovf_irq on the same edge: set wins
    irq_clear = 1'b1; tick(); irq_clear = 1'b0;
    chk("irq_clear2", ovf_irq, 1'b0);
    load(vecs[0]);
    start_line(vecs[0].ny, mke(vecs[0].v, vecs[0].ids, vecs[0].rows, 1'b1, 9));
    wait_idx(3'd7);
    irq_clear = 1'b1; tick(); irq_clear = 1'b0;
    chk("irq_set_wins", {done, ovf_irq}, 2'b11);
    tick();
    chk("irq_held", ovf_irq, 1'b1);
    wait_done();

    // overflow statistics
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (3) run_vec(vecs[0]);
    run_vec(vecs[7]);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
`ifdef SPRITE_SCHED_STATS_EN
    chk("ovf_count_3", ovf_count, 8'd3);
`else
    chk("ovf_count_3", ovf_count, 8'd0);
`endif
    repeat (300) run_vec(vecs[0]);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
`ifdef SPRITE_SCHED_STATS_EN
    chk("ovf_count_sat", ovf_count, 8'd255);
`else
    chk("ovf_count_sat", ovf_count, 8'd0);
`endif
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("ovf_count_empty", ovf_count, 8'd0);

    repeat (3) tick();
    chk("done_count", n_done, n_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
